// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared definitions for the CPU clock controller: state encoding and width defaults.
// The state encoding is also consumed by the core's debug logic.
package cpu_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_TRAP = 2'd3
  } cpu_state_t;

  localparam int DIV_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF = 32;

  // Divider only counts while the core is being paced.
  function automatic logic is_active(input cpu_state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_clock_ctrl_clk_divider.sv
// Reloadable down-counter producing a combinational tick while active.
// The counter is cleared whenever inactive so the first active cycle ticks immediately.
module clk_divider #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] div_cnt;

  assign tick = active && (div_cnt == '0);

  // div is sampled only at reload, so ratio changes take effect at the next period.
  always_ff @(posedge clk) begin
    if (rst || !active) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= div;
    end else begin
      div_cnt <= div_cnt - DIV_ONE;
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step controller: issues a divided one-cycle clock enable to the core
// and counts the enables issued.
module cpu_clock_ctrl
  import cpu_clock_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic                 step_req,
  input  logic                 cpu_halted,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 clr_count,
  output logic                 cpu_en,
  output logic                 step_done,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  cpu_state_t state_q, state_d;
  logic       en_d, step_done_d;
  logic       tick;

  clk_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
    .clk    (clk),
    .rst    (rst),
    .active (is_active(state_q)),
    .div    (div),
    .tick   (tick)
  );

  assign state = state_q;

  // Exits are checked before the tick, so an exiting edge never issues an enable.
  always_comb begin
    state_d     = state_q;
    en_d        = 1'b0;
    step_done_d = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (step_req) state_d = ST_STEP;
        else if (run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req || !run) state_d = ST_HALT;
        else if (cpu_halted)  state_d = ST_TRAP;
        else                  en_d    = tick;
      end
      ST_STEP: begin
        if (halt_req)        state_d = ST_HALT;
        else if (cpu_halted) state_d = ST_TRAP;
        else if (tick) begin
          state_d     = ST_HALT;
          en_d        = 1'b1;
          step_done_d = 1'b1;
        end
      end
      ST_TRAP: begin
        if (!run) state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HALT;
      cpu_en      <= 1'b0;
      step_done   <= 1'b0;
      cycle_count <= '0;
    end else begin
      state_q   <= state_d;
      cpu_en    <= en_d;
      step_done <= step_done_d;
      if (clr_count) cycle_count <= '0;
      else if (cpu_en) cycle_count <= cycle_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: directed scenarios plus randomized traffic checked against
// a cycle-level behavioural model of the run/halt/step rules.
module tb_cpu_clock_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, run, halt_req, step_req, cpu_halted, clr_count;
  logic [DW-1:0] div;
  logic          cpu_en, step_done;
  logic [1:0]    state;
  logic [CW-1:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int en_seen = 0;

  logic [7:0] exp_q[$];

  // model: phase 0=halt 1=run 2=step 3=trap, wait = cycles until next enable slot
  int m_state = 0, m_wait = 0, m_count = 0;
  bit m_en = 0, m_sd = 0;

  cpu_clock_ctrl #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .cpu_halted  (cpu_halted),
    .div         (div),
    .clr_count   (clr_count),
    .cpu_en      (cpu_en),
    .step_done   (step_done),
    .state       (state),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: applies one clock edge's worth of the controller rules.
  task automatic model_edge();
    bit pacing, slot;
    int nxt_count;
    if (rst) begin
      m_state = 0; m_wait = 0; m_count = 0; m_en = 0; m_sd = 0;
    end else begin
      nxt_count = clr_count ? 0 : (m_en ? (m_count + 1) % (1 << CW) : m_count);
      pacing = (m_state == 1) || (m_state == 2);
      slot = pacing && (m_wait == 0);
      m_wait = !pacing ? 0 : (slot ? int'(div) : m_wait - 1);
      m_en = 0;
      m_sd = 0;
      if (m_state == 0) begin
        if (step_req) m_state = 2;
        else if (run) m_state = 1;
      end else if (m_state == 1) begin
        if (halt_req || !run) m_state = 0;
        else if (cpu_halted) m_state = 3;
        else m_en = slot;
      end else if (m_state == 2) begin
        if (halt_req) m_state = 0;
        else if (cpu_halted) m_state = 3;
        else if (slot) begin
          m_state = 0; m_en = 1; m_sd = 1;
        end
      end else begin
        if (!run) m_state = 0;
      end
      m_count = nxt_count;
    end
    exp_q.push_back({2'(m_state), m_en, m_sd, 4'(m_count)});
  endtask

  task automatic cycle();
    logic [7:0] e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = exp_q.pop_front();
    check("state", 32'(state), 32'(e[7:6]));
    check("cpu_en", 32'(cpu_en), 32'(e[5]));
    check("step_done", 32'(step_done), 32'(e[4]));
    check("cycle_count", 32'(cycle_count), 32'(e[3:0]));
    if (cpu_en === 1'b1) en_seen++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 0; halt_req = 0; step_req = 0; cpu_halted = 0; clr_count = 0; div = '0;
    do_reset();
    check("reset_state", 32'(state), 0);
    check("reset_en", 32'(cpu_en), 0);
    check("reset_count", 32'(cycle_count), 0);

    // div=0 free run: enable every cycle starting at the second edge
    div = 0; run = 1;
    cycle();
    check("t1_state_run", 32'(state), 1);
    check("t1_no_en_yet", 32'(cpu_en), 0);
    cycle();
    check("t1_first_en", 32'(cpu_en), 1);
    cycle();
    check("t1_en_again", 32'(cpu_en), 1);
    check("t1_count1", 32'(cycle_count), 1);
    cycle();
    check("t1_count2", 32'(cycle_count), 2);

    // div=3 for 20 edges: five enables, count 5
    run = 0; do_reset();
    div = 3; run = 1; en_seen = 0;
    cycles(20);
    check("t2_pulses", 32'(en_seen), 5);
    check("t2_count", 32'(cycle_count), 5);

    // single step from HALT
    run = 0; do_reset();
    div = 5; step_req = 1;
    cycle();
    step_req = 0;
    check("t3_in_step", 32'(state), 2);
    cycle();
    check("t3_en", 32'(cpu_en), 1);
    check("t3_step_done", 32'(step_done), 1);
    check("t3_back_halt", 32'(state), 0);
    en_seen = 0;
    cycles(6);
    check("t3_no_more_en", 32'(en_seen), 0);
    check("t3_count", 32'(cycle_count), 1);

    // cpu_halted traps; step ignored; run=0 leaves
    do_reset();
    div = 1; run = 1;
    cycles(5);
    cpu_halted = 1;
    cycle();
    check("t4_trap", 32'(state), 3);
    check("t4_en_off", 32'(cpu_en), 0);
    step_req = 1; halt_req = 1;
    cycle();
    step_req = 0; halt_req = 0;
    en_seen = 0;
    cycles(4);
    check("t4_stay_trap", 32'(state), 3);
    check("t4_no_en", 32'(en_seen), 0);
    run = 0;
    cycle();
    check("t4_leave_halt", 32'(state), 0);
    cpu_halted = 0;

    // halt_req on the step's tick edge cancels the enable
    do_reset();
    div = 2; step_req = 1;
    cycle();
    step_req = 0; halt_req = 1;
    cycle();
    halt_req = 0;
    check("t5_state", 32'(state), 0);
    check("t5_en", 32'(cpu_en), 0);
    check("t5_step_done", 32'(step_done), 0);
    cycle();
    check("t5_count", 32'(cycle_count), 0);

    // counter wrap, clear priority, reset mid-run
    do_reset();
    div = 0; run = 1;
    cycles(17);
    check("t6_count15", 32'(cycle_count), 15);
    cycle();
    check("t6_wrap", 32'(cycle_count), 0);
    clr_count = 1;
    cycle();
    clr_count = 0;
    check("t6_clr_en", 32'(cpu_en), 1);
    check("t6_clr_wins", 32'(cycle_count), 0);
    rst = 1;
    cycle();
    rst = 0;
    check("t6_rst_state", 32'(state), 0);
    check("t6_rst_en", 32'(cpu_en), 0);
    check("t6_rst_sd", 32'(step_done), 0);
    check("t6_rst_count", 32'(cycle_count), 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      halt_req   = ($urandom_range(0, 19) == 0);
      step_req   = ($urandom_range(0, 11) == 0);
      clr_count  = ($urandom_range(0, 29) == 0);
      rst        = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) cpu_halted = ~cpu_halted;
      if ($urandom_range(0, 24) == 0) div = DW'($urandom_range(0, 4));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
